// File: rtl/load_store_unit.sv
// Memory-access stage: decodes uPower loads/stores, checks alignment, runs one
// doubleword req/ack transaction and returns extended load data as a writeback strobe.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        err_valid,
    output logic [1:0]  err_code
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       store;
        logic       sext;
        logic [1:0] size;
    } dec_t;

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        case (op)
            6'd32:   d = {1'b1, 1'b0, 1'b0, SZ_W};
            6'd34:   d = {1'b1, 1'b0, 1'b0, SZ_B};
            6'd36:   d = {1'b1, 1'b1, 1'b0, SZ_W};
            6'd38:   d = {1'b1, 1'b1, 1'b0, SZ_B};
            6'd40:   d = {1'b1, 1'b0, 1'b0, SZ_H};
            6'd42:   d = {1'b1, 1'b0, 1'b1, SZ_H};
            6'd44:   d = {1'b1, 1'b1, 1'b0, SZ_H};
            6'd58:   d = {1'b1, 1'b0, 1'b0, SZ_D};
            6'd62:   d = {1'b1, 1'b1, 1'b0, SZ_D};
            default: d = 5'b0_0_0_00;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic m;
        case (size)
            SZ_H:    m = off[0];
            SZ_W:    m = (off[1:0] != 2'b00);
            SZ_D:    m = (off != 3'b000);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] lane_be(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] be;
        case (size)
            SZ_B:    be = 8'h01 << off;
            SZ_H:    be = 8'h03 << off;
            SZ_W:    be = 8'h0F << off;
            default: be = 8'hFF;
        endcase
        return be;
    endfunction

    function automatic logic [63:0] lane_wdata(input logic [1:0] size, input logic [63:0] w);
        logic [63:0] d;
        case (size)
            SZ_B:    d = {8{w[7:0]}};
            SZ_H:    d = {4{w[15:0]}};
            SZ_W:    d = {2{w[31:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    // Shift the addressed byte down to lane 0, then trim and extend to the access size.
    function automatic logic [63:0] extract(input logic [63:0] rdata, input logic [2:0] off,
                                            input logic [1:0] size, input logic sext);
        logic [63:0] sh;
        logic [63:0] r;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_B:    r = {56'd0, sh[7:0]};
            SZ_H: begin
                if (sext) begin
                    r = {{48{sh[15]}}, sh[15:0]};
                end else begin
                    r = {48'd0, sh[15:0]};
                end
            end
            SZ_W:    r = {32'd0, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       err_code_next_s;
    logic             accept_s;
    logic             issue_s;
    dec_t             dec_s;
    logic             mis_s;

    logic             op_store_r;
    logic             op_sext_r;
    logic [1:0]       op_size_r;
    logic [2:0]       op_off_r;
    logic [4:0]       op_rd_r;

    logic             req_ready_r, mem_req_r, mem_we_r, wb_valid_r, err_valid_r;
    logic [63:0]      mem_addr_r, mem_wdata_r, wb_data_r;
    logic [7:0]       mem_be_r;
    logic [4:0]       wb_rd_r;
    logic [1:0]       err_code_r;

    // Next-state decode; illegal opcode takes priority over misalignment.
    always_comb begin
        state_next_s    = state_r;
        err_code_next_s = 2'd0;
        accept_s        = 1'b0;
        issue_s         = 1'b0;
        dec_s           = decode_op(req_opcode);
        mis_s           = misaligned(dec_s.size, req_addr[2:0]);
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    if (!dec_s.legal) begin
                        state_next_s    = ST_ERR;
                        err_code_next_s = 2'd2;
                    end else if (mis_s) begin
                        state_next_s    = ST_ERR;
                        err_code_next_s = 2'd1;
                    end else begin
                        state_next_s = ST_ISSUE;
                        issue_s      = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    state_next_s = op_store_r ? ST_IDLE : ST_WB;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s    = ST_ERR;
                    err_code_next_s = 2'd3;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WB:   state_next_s = ST_IDLE;
            ST_ERR:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and wait-for-ack counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_ISSUE && state_next_s == ST_ISSUE) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Operation attributes latched on the accept cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_store_r <= 1'b0;
            op_sext_r  <= 1'b0;
            op_size_r  <= 2'd0;
            op_off_r   <= 3'd0;
            op_rd_r    <= 5'd0;
        end else if (accept_s) begin
            op_store_r <= dec_s.store;
            op_sext_r  <= dec_s.sext;
            op_size_r  <= dec_s.size;
            op_off_r   <= req_addr[2:0];
            op_rd_r    <= req_rd;
        end
    end

    // Registered outputs; strobes follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 64'd0;
            mem_be_r    <= 8'd0;
            mem_wdata_r <= 64'd0;
            wb_valid_r  <= 1'b0;
            wb_rd_r     <= 5'd0;
            wb_data_r   <= 64'd0;
            err_valid_r <= 1'b0;
            err_code_r  <= 2'd0;
        end else begin
            req_ready_r <= (state_next_s == ST_IDLE);
            mem_req_r   <= (state_next_s == ST_ISSUE);
            wb_valid_r  <= (state_next_s == ST_WB);
            err_valid_r <= (state_next_s == ST_ERR);
            err_code_r  <= err_code_next_s;
            if (issue_s) begin
                mem_we_r    <= dec_s.store;
                mem_addr_r  <= {req_addr[63:3], 3'b000};
                mem_be_r    <= dec_s.store ? lane_be(dec_s.size, req_addr[2:0]) : 8'hFF;
                mem_wdata_r <= dec_s.store ? lane_wdata(dec_s.size, req_wdata) : 64'd0;
            end else if (state_next_s != ST_ISSUE) begin
                mem_we_r    <= 1'b0;
                mem_addr_r  <= 64'd0;
                mem_be_r    <= 8'd0;
                mem_wdata_r <= 64'd0;
            end
            // Writeback payload holds until the next load completes.
            if (state_r == ST_ISSUE && mem_ack && !op_store_r) begin
                wb_data_r <= extract(mem_rdata, op_off_r, op_size_r, op_sext_r);
                wb_rd_r   <= op_rd_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;
    assign wb_valid  = wb_valid_r;
    assign wb_rd     = wb_rd_r;
    assign wb_data   = wb_data_r;
    assign err_valid = err_valid_r;
    assign err_code  = err_code_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected memory, writeback
// and error events; a negedge monitor pops and compares them as the DUT emits them.
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_opcode = 6'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = 64'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        err_valid;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_valid(err_valid), .err_code(err_code)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 memory request, 1 writeback, 2 error
    typedef struct {
        int          kind;
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [1:0]  code;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    logic [63:0] mem_model [int];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic we, input logic [63:0] addr,
                        input logic [7:0] be, input logic [63:0] wdata, input logic [4:0] rd,
                        input logic [63:0] data, input logic [1:0] code, input int at);
        exp_t e;
        e.kind = kind; e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
        e.rd = rd; e.data = data; e.code = code; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s unexpected: got event at cycle %0d, expected none", name, cyc);
        end else begin
            e = exp_q.pop_front();
            check({name, " kind"}, 64'(kind), 64'(e.kind));
            check({name, " cycle"}, 64'(cyc), 64'(e.at));
            if (kind == 0) begin
                check({name, " we"}, 64'(mem_we), 64'(e.we));
                check({name, " addr"}, mem_addr, e.addr);
                check({name, " be"}, 64'(mem_be), 64'(e.be));
                if (e.we) check({name, " wdata"}, mem_wdata, e.wdata);
            end else if (kind == 1) begin
                check({name, " rd"}, 64'(wb_rd), 64'(e.rd));
                check({name, " data"}, wb_data, e.data);
            end else begin
                check({name, " code"}, 64'(err_code), 64'(e.code));
                check({name, " mem_req"}, 64'(mem_req), 64'd0);
            end
        end
    endtask

    // Monitor: every rising mem_req and every strobe consumes one expectation.
    logic mem_req_d = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_req_d <= 1'b0;
        end else begin
            if (mem_req && !mem_req_d) take(0, "mem");
            if (wb_valid) take(1, "wb");
            if (err_valid) take(2, "err");
            mem_req_d <= mem_req;
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
        check("req_ready wait", 64'(req_ready), 64'd1);
    endtask

    // Entered at a negedge; returns 1ns after the accept edge.
    task automatic accept(input logic [5:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [4:0] rd, output int c0);
        wait_ready();
        req_valid = 1'b1; req_opcode = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        c0 = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_opcode = 6'd0; req_addr = 64'd0; req_wdata = 64'd0; req_rd = 5'd0;
    endtask

    // Ack during the k-th cycle of mem_req; returns at the negedge after the ack edge.
    task automatic ack_at(input int k, input logic [63:0] rdata);
        repeat (k) @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = rdata;
        if (mem_we) begin
            logic [63:0] w;
            w = mem_model.exists(int'(mem_addr >> 3)) ? mem_model[int'(mem_addr >> 3)] : 64'd0;
            for (int b = 0; b < 8; b++) if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
            mem_model[int'(mem_addr >> 3)] = w;
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
        mem_rdata = 64'd0;
        @(negedge clk);
    endtask

    task automatic run_store(input logic [5:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [7:0] be, input logic [63:0] ewd);
        int c0;
        accept(op, addr, wdata, 5'd0, c0);
        push(0, 1'b1, addr & ~64'd7, be, ewd, 5'd0, 64'd0, 2'd0, c0 + 1);
        ack_at(1, 64'd0);
        check("store req_ready", 64'(req_ready), 64'd1);
    endtask

    // k = 0 means never acknowledge (timeout path).
    task automatic run_load(input logic [5:0] op, input logic [63:0] addr, input logic [4:0] rd,
                            input logic [63:0] rdata, input int k, input logic [63:0] edata);
        int c0;
        accept(op, addr, 64'd0, rd, c0);
        push(0, 1'b0, addr & ~64'd7, 8'hFF, 64'd0, 5'd0, 64'd0, 2'd0, c0 + 1);
        if (k > 0) begin
            push(1, 1'b0, 64'd0, 8'd0, 64'd0, rd, edata, 2'd0, c0 + k + 1);
            ack_at(k, rdata);
        end else begin
            push(2, 1'b0, 64'd0, 8'd0, 64'd0, 5'd0, 64'd0, 2'd3, c0 + TO + 1);
            repeat (TO + 1) @(negedge clk);
        end
        check("strobe req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("after strobe req_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic run_err(input logic [5:0] op, input logic [63:0] addr, input logic [1:0] code);
        int c0;
        accept(op, addr, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, c0);
        push(2, 1'b0, 64'd0, 8'd0, 64'd0, 5'd0, 64'd0, code, c0 + 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst mem_req", 64'(mem_req), 64'd0);
        check("rst mem_be", 64'(mem_be), 64'd0);
        check("rst wb_data", wb_data, 64'd0);
        check("rst err_code", 64'(err_code), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_store(6'd38, 64'h13, 64'hAB, 8'h08, 64'hABAB_ABAB_ABAB_ABAB);
        run_load(6'd42, 64'h22, 5'd5, 64'h0000_0000_8001_0000, 1, 64'hFFFF_FFFF_FFFF_8001);
        run_err(6'd32, 64'h06, 2'd1);
        run_err(6'd7, 64'h00, 2'd2);
        run_err(6'd44, 64'h01, 2'd1);
        run_err(6'd62, 64'h44, 2'd1);
        run_load(6'd58, 64'h40, 5'd2, 64'd0, 0, 64'd0);
        run_load(6'd40, 64'h0A, 5'd7, 64'h1122_3344_5566_7788, TO, 64'h5566);
        run_load(6'd34, 64'h35, 5'd3, 64'h0102_0304_0506_0708, 1, 64'h03);
        run_load(6'd32, 64'h1C, 5'd9, 64'hDEAD_BEEF_0000_0000, 1, 64'hDEAD_BEEF);
        run_load(6'd42, 64'h00, 5'd1, 64'h0000_0000_0000_7FFF, 2, 64'h7FFF);
        run_store(6'd44, 64'h0E, 64'hFFFF_0000_0000_1234, 8'hC0, 64'h1234_1234_1234_1234);
        run_store(6'd36, 64'h04, 64'h1_CAFE_F00D, 8'hF0, 64'hCAFE_F00D_CAFE_F00D);

        // Stray ack while idle must not produce anything.
        mem_ack = 1'b1;
        mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("idle ack wb_valid", 64'(wb_valid), 64'd0);
        check("idle ack mem_req", 64'(mem_req), 64'd0);
        check("idle ack wb_data", wb_data, 64'h7FFF);

        // Reset during ISSUE drops mem_req without waiting for a clock.
        accept(6'd58, 64'h80, 64'd0, 5'd4, c0);
        push(0, 1'b0, 64'h80, 8'hFF, 64'd0, 5'd0, 64'd0, 2'd0, c0 + 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst mem_req", 64'(mem_req), 64'd0);
        check("async rst req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post rst wb_valid", 64'(wb_valid), 64'd0);
        check("post rst err_valid", 64'(err_valid), 64'd0);
        check("post rst req_ready", 64'(req_ready), 64'd1);

        run_store(6'd62, 64'h40, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
        run_load(6'd58, 64'h40, 5'd12,
                 mem_model.exists(8) ? mem_model[8] : 64'd0, 1, 64'h0123_4567_89AB_CDEF);

        repeat (3) @(negedge clk);
        check("queue drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
